// File: rtl/ahb2fifo_pkg.sv
// Shared encodings, header layout and FSM states for the AHB slave to FIFO bridge.
// burst_len maps HBURST onto the number of data beats moved per header.
package ahb2fifo_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam int HDR_WRITE_LSB = 0;
  localparam int HDR_TRANS_LSB = 1;
  localparam int HDR_BURST_LSB = 3;
  localparam int HDR_SIZE_LSB  = 6;
  localparam int HDR_W         = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR,
    ST_WDATA,
    ST_RWAIT,
    ST_RDATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Undefined-length INCR moves a single beat per header, like SINGLE.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
      HBURST_SINGLE, HBURST_INCR:   len = 5'd1;
      default:                      len = 5'd1;
    endcase
    return len;
  endfunction

  function automatic logic [HDR_W-1:0] make_header(input logic [2:0] hsize,
                                                   input logic [2:0] hburst,
                                                   input logic [1:0] htrans,
                                                   input logic       hwrite);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_SIZE_LSB  +: 3] = hsize;
    h[HDR_BURST_LSB +: 3] = hburst;
    h[HDR_TRANS_LSB +: 2] = htrans;
    h[HDR_WRITE_LSB]      = hwrite;
    return h;
  endfunction

endpackage

// File: rtl/ahb2fifo_read_timer.sv
// Read-beat timeout counter plus the drain counter that discards read data
// still owed by the backward FIFO after a timed-out burst.
module ahb2fifo_read_timer
  import ahb2fifo_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       rd_wait,
  input  logic       rd_pop,
  input  logic       brd_vld,
  input  logic [4:0] beats_left,
  output logic       tmo_hit,
  output logic       tmo_evt,
  output logic       drain_active,
  output logic [4:0] drain_cnt
);

  localparam int TW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [TW-1:0] tmo_cnt;

  assign drain_active = (drain_cnt != 5'd0);
  assign tmo_hit      = (TIMEOUT != 0) && rd_wait && !rd_pop && (tmo_cnt == TW'(TMO_LAST));

  // The counter only runs while a beat is owed and none arrives; a hit ends the burst.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      tmo_cnt   <= '0;
      tmo_evt   <= 1'b0;
      drain_cnt <= 5'd0;
    end else begin
      tmo_evt <= tmo_hit;
      if (!rd_wait || rd_pop || tmo_hit)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_hit)
        drain_cnt <= beats_left;
      else if (drain_active && brd_vld)
        drain_cnt <= drain_cnt - 5'd1;
    end
  end

endmodule

// File: rtl/ahb2fifo_slave_bridge.sv
// AHB slave that serialises each transaction into the forward FIFO as
// header, address and write data, and returns read beats from the backward FIFO.
module ahb2fifo_slave_bridge
  import ahb2fifo_pkg::*;
#(
  parameter int DW      = 32,
  parameter int FIFO_AW = 5,
  parameter int TIMEOUT = 256
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DW-1:0]     HWDATA,
  output logic [DW-1:0]     HRDATA,
  output logic [1:0]        HRESP,
  input  logic              HREADYin,
  output logic              HREADYout,
  output logic              fwr_clk,
  input  logic              fwr_rdy,
  output logic              fwr_vld,
  output logic [DW-1:0]     fwr_dat,
  input  logic [FIFO_AW:0]  fwr_cnt,
  output logic              brd_clk,
  output logic              brd_rdy,
  input  logic              brd_vld,
  input  logic [DW-1:0]     brd_dat,
  input  logic [FIFO_AW:0]  brd_cnt,
  output logic              tmo_evt
);

  state_t      state, state_next;
  logic [2:0]  hsize_q, hburst_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic [31:0] haddr_q;
  logic [4:0]  len_q, beat_cnt, beats_left, drain_cnt;
  logic [DW-1:0] hrdata_q;
  logic        new_txn, capture, last_wbeat, hdr_ok;
  logic        fwr_push, rd_rdy, rd_pop, tmo_hit, drain_active;
  logic        unused_brd_cnt;

  assign fwr_clk = HCLK;
  assign brd_clk = HCLK;
  assign HRDATA  = hrdata_q;

  // Occupancy is informational only; read pops are decided by brd_vld.
  assign unused_brd_cnt = ^brd_cnt;

  assign new_txn    = HSEL && HREADYin && HTRANS[1];
  assign last_wbeat = (beat_cnt == len_q - 5'd1);
  assign capture    = new_txn && ((state == ST_IDLE) || ((state == ST_WDATA) && last_wbeat));
  assign beats_left = len_q - beat_cnt;
  assign hdr_ok     = (32'(fwr_cnt) >= 32'(len_q) + 32'd2) && (hwrite_q || !drain_active);
  assign fwr_push   = fwr_vld && fwr_rdy;
  assign rd_pop     = rd_rdy && brd_vld && !drain_active;
  assign brd_rdy    = rd_rdy || drain_active;

  ahb2fifo_read_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .rd_wait      (rd_rdy),
    .rd_pop       (rd_pop),
    .brd_vld      (brd_vld),
    .beats_left   (beats_left),
    .tmo_hit      (tmo_hit),
    .tmo_evt      (tmo_evt),
    .drain_active (drain_active),
    .drain_cnt    (drain_cnt)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (new_txn) state_next = ST_HDR;
      ST_HDR:   if (fwr_push) state_next = ST_ADDR;
      ST_ADDR:  if (fwr_push) state_next = hwrite_q ? ST_WDATA : ST_RWAIT;
      ST_WDATA: if (last_wbeat) state_next = new_txn ? ST_HDR : ST_IDLE;
      ST_RWAIT: begin
        if (rd_pop)       state_next = ST_RDATA;
        else if (tmo_hit) state_next = ST_ERR1;
      end
      ST_RDATA: begin
        if (beats_left == 5'd0) state_next = ST_IDLE;
        else if (rd_pop)        state_next = ST_RDATA;
        else if (tmo_hit)       state_next = ST_ERR1;
        else                    state_next = ST_RWAIT;
      end
      ST_ERR1:  state_next = ST_ERR2;
      ST_ERR2:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // RDATA is the cycle a popped beat is presented, so HREADYout follows the state.
  always_comb begin
    HREADYout = 1'b1;
    HRESP     = HRESP_OKAY;
    fwr_vld   = 1'b0;
    fwr_dat   = '0;
    rd_rdy    = 1'b0;
    case (state)
      ST_HDR: begin
        HREADYout = 1'b0;
        fwr_vld   = hdr_ok;
        fwr_dat   = DW'(make_header(hsize_q, hburst_q, htrans_q, hwrite_q));
      end
      ST_ADDR: begin
        HREADYout = 1'b0;
        fwr_vld   = 1'b1;
        fwr_dat   = DW'(haddr_q);
      end
      ST_WDATA: begin
        fwr_vld = 1'b1;
        fwr_dat = HWDATA;
      end
      ST_RWAIT: begin
        HREADYout = 1'b0;
        rd_rdy    = (beats_left != 5'd0);
      end
      ST_RDATA: rd_rdy = (beats_left != 5'd0);
      ST_ERR1: begin
        HREADYout = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hsize_q  <= 3'd0;
      hburst_q <= 3'd0;
      htrans_q <= 2'd0;
      hwrite_q <= 1'b0;
      haddr_q  <= 32'd0;
      len_q    <= 5'd1;
      beat_cnt <= 5'd0;
      hrdata_q <= '0;
    end else begin
      if (capture) begin
        hsize_q  <= HSIZE;
        hburst_q <= HBURST;
        htrans_q <= HTRANS;
        hwrite_q <= HWRITE;
        haddr_q  <= HADDR;
        len_q    <= burst_len(HBURST);
      end
      if (state == ST_ADDR)
        beat_cnt <= 5'd0;
      else if ((state == ST_WDATA) || rd_pop)
        beat_cnt <= beat_cnt + 5'd1;
      if (rd_pop)
        hrdata_q <= brd_dat;
    end
  end

endmodule

// File: tb/tb_ahb2fifo_slave_bridge.sv
// Directed bench: models both FIFOs with queues and checks the bus side
// and the forward word stream against hand-computed values.
module tb_ahb2fifo_slave_bridge;
  import ahb2fifo_pkg::*;

  localparam int DW      = 32;
  localparam int FIFO_AW = 5;
  localparam int TIMEOUT = 16;

  logic              HCLK = 1'b0;
  logic              HRESETn, HSEL, HWRITE, HREADYin, HREADYout;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS, HRESP;
  logic [2:0]        HSIZE, HBURST;
  logic [DW-1:0]     HWDATA, HRDATA;
  logic              fwr_clk, fwr_rdy, fwr_vld, brd_clk, brd_rdy, brd_vld, tmo_evt;
  logic [DW-1:0]     fwr_dat, brd_dat;
  logic [FIFO_AW:0]  fwr_cnt, brd_cnt;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] bq[$];
  logic [DW-1:0] exq[$];
  logic [DW-1:0] rdv[$];
  logic          brd_en;

  always #5 HCLK = ~HCLK;

  ahb2fifo_slave_bridge #(.DW(DW), .FIFO_AW(FIFO_AW), .TIMEOUT(TIMEOUT)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HRESP(HRESP), .HREADYin(HREADYin), .HREADYout(HREADYout),
    .fwr_clk(fwr_clk), .fwr_rdy(fwr_rdy), .fwr_vld(fwr_vld), .fwr_dat(fwr_dat),
    .fwr_cnt(fwr_cnt), .brd_clk(brd_clk), .brd_rdy(brd_rdy), .brd_vld(brd_vld),
    .brd_dat(brd_dat), .brd_cnt(brd_cnt), .tmo_evt(tmo_evt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refreshBrd();
    brd_vld = brd_en && (bq.size() != 0);
    brd_dat = (bq.size() != 0) ? bq[0] : '0;
    brd_cnt = (FIFO_AW+1)'(bq.size());
  endtask

  // Handshakes are sampled on the falling edge; inputs change just after the rising edge.
  task automatic cyc();
    logic pop, push;
    logic [DW-1:0] pd;
    @(negedge HCLK);
    pop  = brd_rdy && brd_vld;
    push = fwr_vld && fwr_rdy;
    pd   = fwr_dat;
    @(posedge HCLK);
    #1;
    if (pop) void'(bq.pop_front());
    if (push) fq.push_back(pd);
    refreshBrd();
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [2:0] burst);
    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HWRITE = wr;
    HADDR  = addr;
    HBURST = burst;
    HSIZE  = 3'd2;
    cyc();
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
  endtask

  task automatic checkFwd(input string tag);
    checkOutput($sformatf("%s_len", tag), 64'(fq.size()), 64'(exq.size()));
    for (int i = 0; i < exq.size(); i++)
      checkOutput($sformatf("%s[%0d]", tag, i), (i < fq.size()) ? 64'(fq[i]) : 64'hdead, 64'(exq[i]));
    fq.delete();
    exq.delete();
  endtask

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    HSIZE = 3'd0; HBURST = 3'd0; HWDATA = '0; HREADYin = 1'b1;
    fwr_rdy = 1'b1; fwr_cnt = 6'd32; brd_en = 1'b1;
    refreshBrd();
    cyc(); cyc();
    checkOutput("rst_hready", HREADYout, 1);
    checkOutput("rst_hresp", HRESP, 0);
    checkOutput("rst_hrdata", HRDATA, 0);
    checkOutput("rst_fwr_vld", fwr_vld, 0);
    checkOutput("rst_fwr_dat", fwr_dat, 0);
    checkOutput("rst_brd_rdy", brd_rdy, 0);
    checkOutput("rst_tmo_evt", tmo_evt, 0);
    HRESETn = 1'b1;
    cyc();

    // SINGLE write
    applyStimulus(1'b1, 32'h1000, HBURST_SINGLE);
    checkOutput("w1_hdr_hready", HREADYout, 0);
    checkOutput("w1_hdr_dat", fwr_dat, 32'h85);
    cyc();
    checkOutput("w1_addr_hready", HREADYout, 0);
    HWDATA = 32'hA5A5A5A5;
    cyc();
    checkOutput("w1_data_hready", HREADYout, 1);
    cyc();
    checkOutput("w1_idle_fwr_vld", fwr_vld, 0);
    exq = '{32'h85, 32'h1000, 32'hA5A5A5A5};
    checkFwd("w1_fwd");

    // INCR4 read, data preloaded
    rdv = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    bq = rdv;
    refreshBrd();
    applyStimulus(1'b0, 32'h2000, HBURST_INCR4);
    checkOutput("r4_hdr_dat", fwr_dat, 32'h9C);
    cyc(); cyc();
    checkOutput("r4_rwait_hready", HREADYout, 0);
    checkOutput("r4_rwait_brd_rdy", brd_rdy, 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("r4_hready%0d", i), HREADYout, 1);
      checkOutput($sformatf("r4_hrdata%0d", i), HRDATA, rdv[i]);
      checkOutput($sformatf("r4_hresp%0d", i), HRESP, 0);
      cyc();
    end
    checkOutput("r4_end_state", dut.state, ST_IDLE);
    checkOutput("r4_bq_empty", bq.size(), 0);
    exq = '{32'h9C, 32'h2000};
    checkFwd("r4_fwd");

    // INCR8 read with a three-cycle gap after beat 2
    rdv.delete();
    for (int i = 0; i < 8; i++) rdv.push_back(32'h30 + i);
    bq = rdv;
    refreshBrd();
    applyStimulus(1'b0, 32'h3000, HBURST_INCR8);
    cyc(); cyc(); cyc();
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("r8_hready%0d", i), HREADYout, 1);
      checkOutput($sformatf("r8_hrdata%0d", i), HRDATA, rdv[i]);
      if (i == 1) begin
        brd_en = 1'b0;
        refreshBrd();
      end
      cyc();
      if (i == 1) begin
        for (int g = 0; g < 3; g++) begin
          checkOutput($sformatf("r8_gap%0d", g), HREADYout, 0);
          checkOutput($sformatf("r8_gap_resp%0d", g), HRESP, 0);
          if (g == 2) begin
            brd_en = 1'b1;
            refreshBrd();
          end
          cyc();
        end
      end
    end
    checkOutput("r8_tmo_evt", tmo_evt, 0);
    checkOutput("r8_end_state", dut.state, ST_IDLE);
    exq = '{32'hAC, 32'h3000};
    checkFwd("r8_fwd");

    // INCR4 read that times out after one beat
    bq = '{32'hD1D1D1D1};
    refreshBrd();
    applyStimulus(1'b0, 32'h5000, HBURST_INCR4);
    cyc(); cyc(); cyc();
    checkOutput("to_beat0", HRDATA, 32'hD1D1D1D1);
    for (int k = 1; k < 16; k++) begin
      cyc();
      checkOutput($sformatf("to_wait%0d_hready", k), HREADYout, 0);
      checkOutput($sformatf("to_wait%0d_evt", k), tmo_evt, 0);
    end
    cyc();
    checkOutput("to_err1_evt", tmo_evt, 1);
    checkOutput("to_err1_resp", HRESP, 1);
    checkOutput("to_err1_hready", HREADYout, 0);
    checkOutput("to_drain_cnt", dut.drain_cnt, 3);
    checkOutput("to_drain_rdy", brd_rdy, 1);
    cyc();
    checkOutput("to_err2_resp", HRESP, 1);
    checkOutput("to_err2_hready", HREADYout, 1);
    checkOutput("to_err2_evt", tmo_evt, 0);
    cyc();
    checkOutput("to_idle_resp", HRESP, 0);
    exq = '{32'h9C, 32'h5000};
    checkFwd("to_fwd");

    // Next read header blocked until three late words are drained
    applyStimulus(1'b0, 32'h6000, HBURST_SINGLE);
    checkOutput("dr_hdr_blk0", fwr_vld, 0);
    cyc();
    checkOutput("dr_hdr_blk1", fwr_vld, 0);
    bq = '{32'hBAD00001, 32'hBAD00002, 32'hBAD00003};
    refreshBrd();
    cyc();
    checkOutput("dr_pop1_blk", fwr_vld, 0);
    cyc();
    checkOutput("dr_pop2_blk", fwr_vld, 0);
    cyc();
    checkOutput("dr_hdr_go", fwr_vld, 1);
    checkOutput("dr_bq_empty", bq.size(), 0);
    checkOutput("dr_hrdata_kept", HRDATA, 32'hD1D1D1D1);
    checkOutput("dr_cnt_zero", dut.drain_cnt, 0);
    bq = '{32'hE1E1E1E1};
    refreshBrd();
    cyc(); cyc(); cyc();
    checkOutput("dr_read_hready", HREADYout, 1);
    checkOutput("dr_read_data", HRDATA, 32'hE1E1E1E1);
    cyc();
    exq = '{32'h84, 32'h6000};
    checkFwd("dr_fwd");

    // INCR4 write with one room short
    fwr_cnt = 6'd5;
    applyStimulus(1'b1, 32'h7000, HBURST_INCR4);
    checkOutput("rm_stall0", fwr_vld, 0);
    cyc();
    checkOutput("rm_stall1", fwr_vld, 0);
    checkOutput("rm_stall_hready", HREADYout, 0);
    fwr_cnt = 6'd6;
    #1;
    checkOutput("rm_room_ok", fwr_vld, 1);
    cyc();
    checkOutput("rm_addr_hready", HREADYout, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rm_wbeat%0d", i), HREADYout, 1);
      HWDATA = 32'hC0DE0000 + i;
      cyc();
    end
    checkOutput("rm_end_state", dut.state, ST_IDLE);
    exq = '{32'h9D, 32'h7000, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
    checkFwd("rm_fwd");
    fwr_cnt = 6'd32;

    // Reset in the middle of a read burst
    bq = '{32'h71, 32'h72, 32'h73, 32'h74};
    refreshBrd();
    applyStimulus(1'b0, 32'h8000, HBURST_INCR4);
    cyc(); cyc(); cyc();
    checkOutput("mr_rdata", HRDATA, 32'h71);
    HRESETn = 1'b0;
    cyc();
    checkOutput("mr_hready", HREADYout, 1);
    checkOutput("mr_hresp", HRESP, 0);
    checkOutput("mr_hrdata", HRDATA, 0);
    checkOutput("mr_fwr_vld", fwr_vld, 0);
    checkOutput("mr_fwr_dat", fwr_dat, 0);
    checkOutput("mr_brd_rdy", brd_rdy, 0);
    checkOutput("mr_tmo_evt", tmo_evt, 0);
    checkOutput("mr_state", dut.state, ST_IDLE);
    checkOutput("mr_drain", dut.drain_cnt, 0);
    HRESETn = 1'b1;
    bq.delete();
    refreshBrd();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
